// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I memory-access stage.
// Holds funct3 codes, FSM encoding and lane helpers.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_DATA,
    RESPOND
  } state_t;

  // Undefined width codes are rejected alongside misalignment.
  function automatic logic bad_access(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(
    input logic [2:0]  f3,
    input logic [31:0] data
  );
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(
    input logic [31:0] w,
    input logic [1:0]  off
  );
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [15:0] half_lane(
    input logic [31:0] w,
    input logic        hi
  );
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign or zero extension.
// Purely combinational; driven from the latched access.
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = byte_lane(rdata, offset);
  assign h = half_lane(rdata, offset[1]);

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LBU:  result = {24'h0, b};
      F3_LHU:  result = {16'h0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_memory_access.sv
// RV32I memory-access stage: address, alignment, bus FSM.
// One outstanding access; loads pulse a writeback, faults pulse.
module data_memory_access
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand1,
  input  logic [31:0] immediate12,
  input  logic [31:0] store_value,
  input  logic [4:0]  rd_index,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_grant,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        writeback_valid,
  output logic [4:0]  writeback_rd,
  output logic [31:0] writeback_value,
  output logic        misaligned_fault,
  output logic        bus_fault,
  output logic [31:0] fault_address
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [31:0] ea, ea_q, sv_q, aligned;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [4:0]  rd_q;
  logic [7:0]  count;
  logic        accept, load_data, fault_set;
  logic        mis_next, bus_next, timeout;

  assign ea      = operand1 + immediate12;
  assign timeout = count == LAST;

  load_align u_align (
    .funct3 (f3_q),
    .offset (ea_q[1:0]),
    .rdata  (mem_rdata),
    .result (aligned)
  );

  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    load_data       = 1'b0;
    fault_set       = 1'b0;
    mis_next        = 1'b0;
    bus_next        = 1'b0;
    request_ready   = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = 32'h0;
    mem_wstrb       = 4'h0;
    mem_wdata       = 32'h0;
    writeback_valid = 1'b0;
    writeback_rd    = 5'h0;
    unique case (state)
      IDLE: begin
        request_ready = 1'b1;
        if (request_valid) begin
          accept = 1'b1;
          if (bad_access(funct3, ea[1:0])) begin
            mis_next  = 1'b1;
            fault_set = 1'b1;
          end else begin
            state_next = REQUEST;
          end
        end
      end
      REQUEST: begin
        mem_req  = 1'b1;
        mem_addr = {ea_q[31:2], 2'b00};
        mem_we   = st_q;
        if (st_q) begin
          mem_wstrb = wstrb_of(f3_q, ea_q[1:0]);
          mem_wdata = wdata_of(f3_q, sv_q);
        end
        if (mem_grant) begin
          if (st_q) begin
            state_next = IDLE;
          end else if (mem_rvalid) begin
            load_data  = 1'b1;
            state_next = RESPOND;
          end else begin
            state_next = WAIT_DATA;
          end
        end else if (timeout) begin
          bus_next   = 1'b1;
          fault_set  = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DATA: begin
        if (mem_rvalid) begin
          load_data  = 1'b1;
          state_next = RESPOND;
        end else if (timeout) begin
          bus_next   = 1'b1;
          fault_set  = 1'b1;
          state_next = IDLE;
        end
      end
      RESPOND: begin
        writeback_valid = 1'b1;
        writeback_rd    = rd_q;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ea_q             <= 32'h0;
      sv_q             <= 32'h0;
      f3_q             <= 3'h0;
      st_q             <= 1'b0;
      rd_q             <= 5'h0;
      count            <= 8'h0;
      writeback_value  <= 32'h0;
      misaligned_fault <= 1'b0;
      bus_fault        <= 1'b0;
      fault_address    <= 32'h0;
    end else begin
      state            <= state_next;
      misaligned_fault <= mis_next;
      bus_fault        <= bus_next;
      if (state_next != state) begin
        count <= 8'h0;
      end else if (state == REQUEST || state == WAIT_DATA) begin
        count <= count + 8'd1;
      end else begin
        count <= 8'h0;
      end
      if (accept) begin
        ea_q <= ea;
        sv_q <= store_value;
        f3_q <= funct3;
        st_q <= is_store;
        rd_q <= rd_index;
      end
      // Misalignment reports the fresh ea; timeouts the latched one.
      if (fault_set) begin
        fault_address <= (state == IDLE) ? ea : ea_q;
      end
      if (load_data) begin
        writeback_value <= aligned;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_access.sv
// Directed bench for the memory-access stage.
// Inputs change 1ns after the edge; outputs sampled there too.
module tb_data_memory_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        request_valid;
  logic        request_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] immediate12;
  logic [31:0] store_value;
  logic [4:0]  rd_index;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_grant;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        writeback_valid;
  logic [4:0]  writeback_rd;
  logic [31:0] writeback_value;
  logic        misaligned_fault;
  logic        bus_fault;
  logic [31:0] fault_address;

  int passed = 0;
  int total  = 0;

  data_memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_ready    (request_ready),
    .is_store         (is_store),
    .funct3           (funct3),
    .operand1         (operand1),
    .immediate12      (immediate12),
    .store_value      (store_value),
    .rd_index         (rd_index),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wstrb        (mem_wstrb),
    .mem_wdata        (mem_wdata),
    .mem_grant        (mem_grant),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .writeback_valid  (writeback_valid),
    .writeback_rd     (writeback_rd),
    .writeback_value  (writeback_value),
    .misaligned_fault (misaligned_fault),
    .bus_fault        (bus_fault),
    .fault_address    (fault_address)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] op1,
    input logic [31:0] imm,
    input logic [31:0] sv,
    input logic [4:0]  rd
  );
    request_valid = 1'b1;
    is_store      = st;
    funct3        = f3;
    operand1      = op1;
    immediate12   = imm;
    store_value   = sv;
    rd_index      = rd;
    step();
    request_valid = 1'b0;
  endtask

  task automatic run_load(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] op1,
    input logic [31:0] imm,
    input logic [4:0]  rd,
    input logic [31:0] rdata,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_val,
    input bit          same
  );
    issue(1'b0, f3, op1, imm, 32'h0, rd);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_busy"}, 32'(request_ready), 32'd0);
    mem_grant = 1'b1;
    if (same) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
    end
    step();
    mem_grant  = 1'b0;
    mem_rvalid = 1'b0;
    if (!same) begin
      check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      check({tag, "_wb_early"}, 32'(writeback_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
    end
    check({tag, "_wbv"}, 32'(writeback_valid), 32'd1);
    check({tag, "_wbrd"}, 32'(writeback_rd), 32'(rd));
    check({tag, "_wbval"}, writeback_value, exp_val);
    step();
    check({tag, "_wb_pulse"}, 32'(writeback_valid), 32'd0);
    check({tag, "_hold"}, writeback_value, exp_val);
    check({tag, "_ready"}, 32'(request_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    request_valid = 1'b0;
    is_store      = 1'b0;
    funct3        = 3'd0;
    operand1      = 32'h0;
    immediate12   = 32'h0;
    store_value   = 32'h0;
    rd_index      = 5'd0;
    mem_grant     = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    step();
    step();
    check("rst_ready", 32'(request_ready), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_wbv", 32'(writeback_valid), 32'd0);
    check("rst_wbval", writeback_value, 32'h0);
    check("rst_faults", {30'h0, misaligned_fault, bus_fault}, 32'h0);
    check("rst_faddr", fault_address, 32'h0);
    reset = 1'b0;
    step();

    run_load("lb", 3'd0, 32'h1000, 32'd3, 5'd5,
             32'h80FF_1234, 32'h1000, 32'hFFFF_FF80, 1'b0);
    run_load("lhu", 3'd5, 32'h2000, 32'd2, 5'd7,
             32'hBEEF_0000, 32'h2000, 32'h0000_BEEF, 1'b0);
    run_load("lh", 3'd1, 32'h2000, 32'd2, 5'd8,
             32'hBEEF_0000, 32'h2000, 32'hFFFF_BEEF, 1'b0);
    run_load("lbu_same", 3'd4, 32'h5000, 32'd1, 5'd9,
             32'h1234_5678, 32'h5000, 32'h0000_0056, 1'b1);
    run_load("wrap", 3'd4, 32'hFFFF_FFFF, 32'd1, 5'd10,
             32'h0000_00C3, 32'h0000_0000, 32'h0000_00C3, 1'b0);
    run_load("lw", 3'd2, 32'h0, 32'h0000_8000, 5'd31,
             32'hCAFE_F00D, 32'h8000, 32'hCAFE_F00D, 1'b0);

    issue(1'b1, 3'd0, 32'h3000, 32'd1, 32'h0000_00AB, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("sb_req", 32'(mem_req), 32'd1);
      check("sb_addr", mem_addr, 32'h3000);
      check("sb_we", 32'(mem_we), 32'd1);
      check("sb_strb", 32'(mem_wstrb), 32'h2);
      check("sb_lane", 32'(mem_wdata[15:8]), 32'hAB);
      check("sb_nowb", 32'(writeback_valid), 32'd0);
      step();
    end
    mem_grant = 1'b1;
    check("sb_req_g", 32'(mem_req), 32'd1);
    step();
    mem_grant = 1'b0;
    check("sb_done_req", 32'(mem_req), 32'd0);
    check("sb_ready", 32'(request_ready), 32'd1);
    check("sb_nowb2", 32'(writeback_valid), 32'd0);

    issue(1'b0, 3'd2, 32'h4000, 32'd2, 32'h0, 5'd3);
    check("mis_pulse", 32'(misaligned_fault), 32'd1);
    check("mis_addr", fault_address, 32'h4002);
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_ready", 32'(request_ready), 32'd1);
    step();
    check("mis_once", 32'(misaligned_fault), 32'd0);
    check("mis_req2", 32'(mem_req), 32'd0);

    issue(1'b0, 3'd3, 32'h4100, 32'd0, 32'h0, 5'd3);
    check("f3_bad", 32'(misaligned_fault), 32'd1);
    step();

    issue(1'b0, 3'd2, 32'h6000, 32'd0, 32'h0, 5'd4);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_fault", 32'(bus_fault), 32'd1);
    check("to_addr", fault_address, 32'h6000);
    check("to_ready", 32'(request_ready), 32'd1);
    check("to_nowb", 32'(writeback_valid), 32'd0);
    step();
    check("to_once", 32'(bus_fault), 32'd0);

    issue(1'b0, 3'd2, 32'h7000, 32'd0, 32'h0, 5'd6);
    mem_grant = 1'b1;
    step();
    mem_grant = 1'b0;
    #2 reset = 1'b1;
    #2;
    check("mrst_ready", 32'(request_ready), 32'd1);
    check("mrst_req", 32'(mem_req), 32'd0);
    check("mrst_wbv", 32'(writeback_valid), 32'd0);
    check("mrst_wbval", writeback_value, 32'h0);
    check("mrst_faddr", fault_address, 32'h0);
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    check("stale_wbv", 32'(writeback_valid), 32'd0);
    check("stale_ready", 32'(request_ready), 32'd1);
    step();
    check("stale_wbv2", 32'(writeback_valid), 32'd0);
    check("stale_val", writeback_value, 32'h0);
    check("stale_fault", {30'h0, misaligned_fault, bus_fault}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_access.md
Name: data_memory_access

Overview:
- Memory-access stage of the RV32I core, between the execute stage and data memory.
- Accepts one load or store per handshake and computes the effective address.
- Checks alignment, drives the data-memory request/grant/rvalid bus, and aligns byte/half load data with sign or zero extension.
- Loads produce a single-cycle writeback pulse. Stores complete silently. Faults report the offending address.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for mem_grant or mem_rvalid before raising bus_fault; range 2..255.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- request_valid  in  1  execute stage presents an access
- request_ready  out  1  stage can accept; transfer when valid & ready
- is_store  in  1  1 = store (SB/SH/SW), 0 = load
- funct3  in  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- operand1  in  32  base register value
- immediate12  in  32  sign-extended 12-bit offset
- store_value  in  32  rs2 value for stores
- rd_index  in  5  load destination register
- mem_req  out  1  data-memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wstrb  out  4  byte-lane write strobes
- mem_wdata  out  32  lane-shifted store data
- mem_grant  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- writeback_valid  out  1  one-cycle pulse, load result valid
- writeback_rd  out  5  destination register
- writeback_value  out  32  aligned, extended load result
- misaligned_fault  out  1  one-cycle pulse
- bus_fault  out  1  one-cycle pulse on timeout
- fault_address  out  32  effective address of the faulting access

Behaviour:
- Reset state: FSM in IDLE. All outputs 0 except request_ready = 1. Timeout counter = 0.
- A reset asserted mid-access abandons the access: no writeback, no fault. Any later mem_rvalid is ignored while in IDLE.
- Effective address: ea = operand1 + immediate12, modulo 2^32, wrap-around allowed.
- FSM states: IDLE, REQUEST, WAIT_DATA, RESPOND.
- IDLE:
  - request_ready = 1.
  - On valid & ready: latch ea, funct3, is_store, store_value, rd_index.
  - Misaligned (half with ea[0] = 1, or word with ea[1:0] != 0), or funct3 in {3, 6, 7}: pulse misaligned_fault next cycle, load fault_address = ea, stay in IDLE. No bus activity.
  - Otherwise go to REQUEST. request_ready drops the cycle after acceptance.
- REQUEST:
  - mem_req = 1 and mem_addr = {ea[31:2], 2'b00}, held stable until grant.
  - Stores: mem_we = 1. Strobes are 0001<<ea[1:0] for byte, 0011<<ea[1:0] for half, 1111 for word. mem_wdata is the store data replicated/shifted into the addressed lanes.
  - On mem_grant: a store returns to IDLE; a load goes to WAIT_DATA. mem_req deasserts the cycle after grant.
- WAIT_DATA:
  - On mem_rvalid, select the lane by ea[1:0] (byte) or ea[1] (half).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; pass LW through.
  - Register the result into writeback_value and go to RESPOND.
  - mem_rvalid in the same cycle as the grant is legal and handled in the grant cycle, going directly to RESPOND.
- RESPOND: writeback_valid = 1 for exactly one cycle with writeback_rd, then IDLE.
- Timeout: the counter increments each cycle in REQUEST or WAIT_DATA and clears on state change. When it reaches TIMEOUT_CYCLES: pulse bus_fault, set fault_address = ea, return to IDLE, no writeback.
- Latency:
  - Load with grant at cycle 1 and rvalid at cycle 2 after acceptance: writeback_valid at cycle 3.
  - Store: request_ready returns the cycle after grant.
- Throughput: one outstanding access. request_ready = 0 in every state except IDLE.
- writeback_value holds its last value when not valid.

Decomposition:
- Shared package rv32_mem_pkg:
  - funct3 constants LB/LH/LW/LBU/LHU and SB/SH/SW.
  - FSM state encoding.
  - Strobe and lane-select helper functions.
- Natural sub-module: load_align, a combinational lane select plus extension from (funct3, ea[1:0], mem_rdata) to a 32-bit result.
- The FSM and counter stay in data_memory_access.

Test Plan:
- LB, operand1 = 0x1000, imm = 3, mem_rdata = 0x80FF_1234, grant and rvalid 1 cycle apart:
  - Required: mem_addr = 0x1000, writeback_value = 0xFFFF_FF80, writeback_valid pulses once with the correct rd.
- LHU, ea = 0x2002, rdata = 0xBEEF_0000:
  - Required: writeback_value = 0x0000_BEEF. LH on the same data gives 0xFFFF_BEEF.
- SB, ea = 0x3001, store_value = 0x0000_00AB:
  - Required: mem_we = 1, mem_wstrb = 0010, mem_wdata[15:8] = 0xAB.
  - Required: mem_req held until grant arrives after a 3-cycle delay; no writeback_valid.
- LW, ea = 0x4002:
  - Required: misaligned_fault pulse, fault_address = 0x4002, mem_req never asserted, request_ready back the next cycle.
- Load with mem_grant withheld:
  - Required: bus_fault after exactly TIMEOUT_CYCLES (16) cycles in REQUEST, FSM back in IDLE.
- Reset asserted in WAIT_DATA, then stale mem_rvalid:
  - Required: all outputs 0, request_ready = 1, no writeback_valid.
  - Required: operand1 = 0xFFFF_FFFF, imm = 1 wraps to ea = 0.
